// File: rtl/rf_read_req_scheduler.sv
// Request FIFO and bank read scheduler for the 4-bank single-ported register file.
// Optional macro RFSCHED_CONFLICT_CNT_EN adds a saturating head-stall counter output.

module rf_sched_bank_port #(
    parameter int ROW_W  = 3,
    parameter int OCID_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss1,
    input  logic              iss2,
    input  logic [ROW_W-1:0]  row1,
    input  logic [ROW_W-1:0]  row2,
    input  logic [OCID_W-1:0] ocid1,
    input  logic [OCID_W-1:0] ocid2,
    output logic              rd_en,
    output logic [ROW_W-1:0]  rd_row,
    output logic              tag_valid,
    output logic [OCID_W-1:0] tag_ocid
);
    assign rd_en  = iss1 | iss2;
    assign rd_row = iss1 ? row1 : (iss2 ? row2 : '0);

    // Tag trails the read by one cycle so it lines up with RF data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_ocid  <= '0;
        end else begin
            tag_valid <= rd_en;
            tag_ocid  <= iss1 ? ocid1 : (iss2 ? ocid2 : '0);
        end
    end
endmodule

module rf_read_req_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_W      = 3,
    parameter int OCID_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Valid_RAU_ReqFIFO,
    input  logic                  Src1_Valid,
    input  logic [1:0]            Src1_Phy_Bank_ID,
    input  logic [ROW_W-1:0]      Src1_Phy_Row_ID,
    input  logic [OCID_W-1:0]     Src1_OCID_RAU_OC,
    input  logic                  Src2_Valid,
    input  logic [1:0]            Src2_Phy_Bank_ID,
    input  logic [ROW_W-1:0]      Src2_Phy_Row_ID,
    input  logic [OCID_W-1:0]     Src2_OCID_RAU_OC,
    input  logic                  ReqFIFO_2op_EN,
    input  logic                  WriteValid,
    input  logic [1:0]            WriteBank,
    output logic                  Full_ReqFIFO_RAU,
    output logic [3:0]            RdEn_RF,
    output logic [4*ROW_W-1:0]    RdRow_RF,
    output logic [3:0]            TagValid_OC,
`ifdef RFSCHED_CONFLICT_CNT_EN
    output logic [4*OCID_W-1:0]   TagOCID_OC,
    output logic [15:0]           ConflictCnt_RF
`else
    output logic [4*OCID_W-1:0]   TagOCID_OC
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              v;
        logic [1:0]        bank;
        logic [ROW_W-1:0]  row;
        logic [OCID_W-1:0] ocid;
    } opnd_t;

    typedef struct packed {
        opnd_t s1;
        opnd_t s2;
        logic  two_op;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, SECOND} state_t;

    req_t             mem [FIFO_DEPTH];
    req_t             in_req, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop, serve;
    logic             d1, d2, d1_nxt, d2_nxt;
    logic             blk1, blk2, iss1, iss2;
    state_t           state_q, state_nxt;

    logic [3:0][ROW_W-1:0]  rd_row_b;
    logic [3:0][OCID_W-1:0] tag_ocid_b;

    always_comb begin
        in_req         = '0;
        in_req.s1.v    = Src1_Valid;
        in_req.s1.bank = Src1_Phy_Bank_ID;
        in_req.s1.row  = Src1_Phy_Row_ID;
        in_req.s1.ocid = Src1_OCID_RAU_OC;
        in_req.s2.v    = Src2_Valid;
        in_req.s2.bank = Src2_Phy_Bank_ID;
        in_req.s2.row  = Src2_Phy_Row_ID;
        in_req.s2.ocid = Src2_OCID_RAU_OC;
        in_req.two_op  = ReqFIFO_2op_EN;
    end

    assign Full_ReqFIFO_RAU = (count == CNT_W'(FIFO_DEPTH));
    assign push      = Valid_RAU_ReqFIFO & (Src1_Valid | Src2_Valid) & ~Full_ReqFIFO_RAU;
    assign head      = mem[rd_ptr];
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:          if (count_nxt != '0) state_nxt = ISSUE;
            ISSUE, SECOND: state_nxt = pop ? ((count_nxt != '0) ? ISSUE : IDLE) : SECOND;
            default:       state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. CDB write wins the bank; a same-bank pair holds src2 until src1 is done.
    always_comb begin
        serve  = (state_q != IDLE);
        blk1   = WriteValid & (WriteBank == head.s1.bank);
        blk2   = WriteValid & (WriteBank == head.s2.bank);
        iss1   = serve & head.s1.v & ~d1 & ~blk1;
        iss2   = serve & head.s2.v & ~d2 & ~blk2 & ~(head.two_op & ~d1);
        d1_nxt = d1 | ~head.s1.v | iss1;
        d2_nxt = d2 | ~head.s2.v | iss2;
        pop    = serve & d1_nxt & d2_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || pop) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else if (serve) begin
            d1 <= d1_nxt;
            d2 <= d2_nxt;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        rf_sched_bank_port #(.ROW_W(ROW_W), .OCID_W(OCID_W)) u_port (
            .clk       (clk),
            .rst       (rst),
            .iss1      (iss1 && (head.s1.bank == 2'(b))),
            .iss2      (iss2 && (head.s2.bank == 2'(b))),
            .row1      (head.s1.row),
            .row2      (head.s2.row),
            .ocid1     (head.s1.ocid),
            .ocid2     (head.s2.ocid),
            .rd_en     (RdEn_RF[b]),
            .rd_row    (rd_row_b[b]),
            .tag_valid (TagValid_OC[b]),
            .tag_ocid  (tag_ocid_b[b])
        );
    end

    assign RdRow_RF   = rd_row_b;
    assign TagOCID_OC = tag_ocid_b;

`ifdef RFSCHED_CONFLICT_CNT_EN
    logic        stall;
    logic [15:0] conflict_cnt;

    assign stall = serve & ((head.s1.v & ~d1 & ~iss1) | (head.s2.v & ~d2 & ~iss2));

    always_ff @(posedge clk) begin
        if (rst)                                   conflict_cnt <= '0;
        else if (stall && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign ConflictCnt_RF = conflict_cnt;
`endif
endmodule

// File: tb/tb_rf_read_req_scheduler.sv
// Randomised and directed bench for rf_read_req_scheduler against a queue-based reference model.
module tb_rf_read_req_scheduler;
    localparam int DEPTH  = 4;
    localparam int ROW_W  = 3;
    localparam int OCID_W = 3;

    logic clk, rst;
    logic Valid_RAU_ReqFIFO, Src1_Valid, Src2_Valid, ReqFIFO_2op_EN, WriteValid;
    logic [1:0] Src1_Phy_Bank_ID, Src2_Phy_Bank_ID, WriteBank;
    logic [ROW_W-1:0] Src1_Phy_Row_ID, Src2_Phy_Row_ID;
    logic [OCID_W-1:0] Src1_OCID_RAU_OC, Src2_OCID_RAU_OC;
    logic Full_ReqFIFO_RAU;
    logic [3:0] RdEn_RF, TagValid_OC;
    logic [4*ROW_W-1:0] RdRow_RF;
    logic [4*OCID_W-1:0] TagOCID_OC;
`ifdef RFSCHED_CONFLICT_CNT_EN
    logic [15:0] ConflictCnt_RF;
`endif

    rf_read_req_scheduler #(.FIFO_DEPTH(DEPTH), .ROW_W(ROW_W), .OCID_W(OCID_W)) dut (
        .clk(clk), .rst(rst),
        .Valid_RAU_ReqFIFO(Valid_RAU_ReqFIFO),
        .Src1_Valid(Src1_Valid), .Src1_Phy_Bank_ID(Src1_Phy_Bank_ID),
        .Src1_Phy_Row_ID(Src1_Phy_Row_ID), .Src1_OCID_RAU_OC(Src1_OCID_RAU_OC),
        .Src2_Valid(Src2_Valid), .Src2_Phy_Bank_ID(Src2_Phy_Bank_ID),
        .Src2_Phy_Row_ID(Src2_Phy_Row_ID), .Src2_OCID_RAU_OC(Src2_OCID_RAU_OC),
        .ReqFIFO_2op_EN(ReqFIFO_2op_EN),
        .WriteValid(WriteValid), .WriteBank(WriteBank),
        .Full_ReqFIFO_RAU(Full_ReqFIFO_RAU),
        .RdEn_RF(RdEn_RF), .RdRow_RF(RdRow_RF),
        .TagValid_OC(TagValid_OC),
`ifdef RFSCHED_CONFLICT_CNT_EN
        .TagOCID_OC(TagOCID_OC),
        .ConflictCnt_RF(ConflictCnt_RF)
`else
        .TagOCID_OC(TagOCID_OC)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v1; bit [1:0] b1; bit [ROW_W-1:0] r1; bit [OCID_W-1:0] o1;
        bit v2; bit [1:0] b2; bit [ROW_W-1:0] r2; bit [OCID_W-1:0] o2;
        bit two;
    } mreq_t;

    mreq_t q[$];
    bit md1, md2;
    logic [3:0] etv;
    logic [3:0][OCID_W-1:0] eto;
    int unsigned ecc;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock, evaluated mid-cycle with the inputs already applied.
    task automatic eval();
        mreq_t h;
        bit n1 = 0, n2 = 0, i1 = 0, i2 = 0, pushok;
        logic [3:0] en = '0;
        logic [3:0][ROW_W-1:0] rows = '0;
        logic [3:0][OCID_W-1:0] ocs = '0;
        if (rst) begin
            q.delete(); md1 = 0; md2 = 0; etv = '0; eto = '0; ecc = 0;
            return;
        end
        if (q.size() != 0) begin
            h  = q[0];
            n1 = h.v1 && !md1;
            n2 = h.v2 && !md2;
            i1 = n1 && !(WriteValid && WriteBank == h.b1);
            i2 = n2 && !(WriteValid && WriteBank == h.b2) && !(h.two && !md1);
            if (i1) begin en[h.b1] = 1; rows[h.b1] = h.r1; ocs[h.b1] = h.o1; end
            if (i2) begin en[h.b2] = 1; rows[h.b2] = h.r2; ocs[h.b2] = h.o2; end
        end
        chk("full",  32'(Full_ReqFIFO_RAU), 32'(q.size() == DEPTH));
        chk("rden",  32'(RdEn_RF), 32'(en));
        chk("rdrow", 32'(RdRow_RF), 32'(rows));
        chk("tagv",  32'(TagValid_OC), 32'(etv));
        chk("tagid", 32'(TagOCID_OC), 32'(eto));
`ifdef RFSCHED_CONFLICT_CNT_EN
        chk("ccnt",  32'(ConflictCnt_RF), ecc);
`endif
        if (((n1 && !i1) || (n2 && !i2)) && ecc < 32'hFFFF) ecc++;
        pushok = Valid_RAU_ReqFIFO && (Src1_Valid || Src2_Valid) && q.size() < DEPTH;
        if (q.size() != 0) begin
            md1 = md1 || i1 || !h.v1;
            md2 = md2 || i2 || !h.v2;
            if (md1 && md2) begin q.pop_front(); md1 = 0; md2 = 0; end
        end
        if (pushok)
            q.push_back('{Src1_Valid, Src1_Phy_Bank_ID, Src1_Phy_Row_ID, Src1_OCID_RAU_OC,
                          Src2_Valid, Src2_Phy_Bank_ID, Src2_Phy_Row_ID, Src2_OCID_RAU_OC,
                          ReqFIFO_2op_EN});
        etv = en;
        eto = ocs;
    endtask

    task automatic cyc();
        #1 eval();
        @(negedge clk);
    endtask

    task automatic set_req(input bit v, input bit s1v, input bit [1:0] b1, input bit [2:0] r1,
                           input bit [2:0] o1, input bit s2v, input bit [1:0] b2,
                           input bit [2:0] r2, input bit [2:0] o2);
        Valid_RAU_ReqFIFO = v;
        Src1_Valid = s1v; Src1_Phy_Bank_ID = b1; Src1_Phy_Row_ID = r1; Src1_OCID_RAU_OC = o1;
        Src2_Valid = s2v; Src2_Phy_Bank_ID = b2; Src2_Phy_Row_ID = r2; Src2_OCID_RAU_OC = o2;
        ReqFIFO_2op_EN = s1v && s2v && (b1 == b2);
    endtask

    task automatic set_wr(input bit wv, input bit [1:0] wb);
        WriteValid = wv; WriteBank = wb;
    endtask

    task automatic idle(input int n);
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wr(0, 0);
        repeat (n) cyc();
    endtask

    int unsigned cc_base;

    initial begin
        clk = 0; rst = 1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wr(0, 0);
        cyc(); cyc();
        rst = 0;
        #1;
        chk("rst_full", 32'(Full_ReqFIFO_RAU), 0);
        chk("rst_rden", 32'(RdEn_RF), 0);
        chk("rst_tagv", 32'(TagValid_OC), 0);
        cyc();

        // Different-bank pair issues together, tags follow a cycle later.
        set_req(1, 1, 0, 2, 3'b000, 1, 2, 5, 3'b001);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("tp1_en", 32'(RdEn_RF), 32'h5);
        chk("tp1_row", 32'(RdRow_RF), 32'((5 << 6) | 2));
        cyc();
        #1;
        chk("tp1_tagv", 32'(TagValid_OC), 32'h5);
        chk("tp1_tagid", 32'(TagOCID_OC), 32'(1 << 6));
        idle(2);

        // Same-bank pair serialises over two cycles.
        set_req(1, 1, 1, 1, 3'b010, 1, 1, 4, 3'b011);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("tp2_en1", 32'(RdEn_RF), 32'h2);
        chk("tp2_row1", 32'(RdRow_RF), 32'(1 << 3));
        cyc();
        #1;
        chk("tp2_en2", 32'(RdEn_RF), 32'h2);
        chk("tp2_row2", 32'(RdRow_RF), 32'(4 << 3));
        cyc();
        #1;
        chk("tp2_tag", 32'(TagOCID_OC), 32'(3 << 3));
        chk("tp2_en3", 32'(RdEn_RF), 0);
        idle(2);

        // CDB write on bank2 holds the read for two cycles.
        cc_base = ecc;
        set_req(1, 1, 2, 6, 3'b100, 0, 0, 0, 0);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wr(1, 2);
        cyc(); cyc();
        set_wr(0, 0);
        #1;
        chk("tp3_en", 32'(RdEn_RF), 32'h4);
`ifdef RFSCHED_CONFLICT_CNT_EN
        chk("tp3_cc", 32'(ConflictCnt_RF), cc_base + 2);
`endif
        cyc();
        idle(2);

        // Fill under a continuous block, then a refused push alongside a pop.
        set_wr(1, 0);
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1, 0, 3'(i), 3'(i), 0, 0, 0, 0);
            cyc();
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("tp4_full", 32'(Full_ReqFIFO_RAU), 1);
        set_req(1, 1, 3, 7, 7, 0, 0, 0, 0);
        set_wr(0, 0);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("tp4_notfull", 32'(Full_ReqFIFO_RAU), 0);
        chk("tp4_cnt3", 32'(q.size()), 3);
        idle(6);
        for (int i = 0; i < 10; i++) begin
            set_req(1, 1, 2'(i), 3'(i), 3'(i), 0, 0, 0, 0);
            cyc();
        end
        idle(4);

        // No valid source: dropped.
        set_req(1, 0, 1, 1, 1, 0, 2, 2, 2);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("tp5_en", 32'(RdEn_RF), 0);
        cyc();

        // Reset while the head is mid same-bank pair with a second entry queued.
        set_req(1, 1, 3, 1, 1, 1, 3, 2, 2);
        cyc();
        set_req(1, 1, 0, 3, 3, 0, 0, 0, 0);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("tp6_full", 32'(Full_ReqFIFO_RAU), 0);
        chk("tp6_en", 32'(RdEn_RF), 0);
        chk("tp6_tagv", 32'(TagValid_OC), 0);
        cyc();
        set_req(1, 1, 1, 5, 6, 0, 0, 0, 0);
        cyc();
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("tp6_reissue", 32'(RdEn_RF), 32'h2);
        cyc();
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_req($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 2'($urandom),
                    3'($urandom), 3'($urandom), $urandom_range(0, 1) == 1, 2'($urandom),
                    3'($urandom), 3'($urandom));
            set_wr($urandom_range(0, 9) < 3, 2'($urandom));
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_read_req_scheduler.md
Name: rf_read_req_scheduler

Overview:
- Consumer side of the register-allocation/mapping unit's read-request interface: the ReqFIFO plus the bank read scheduler.
- Accepts per-instruction physical source-operand requests (bank, row, OC slot ID) from the mapping unit and buffers them in order.
- Issues reads to the 4 single-ported register-file banks, serialising same-bank operand pairs and yielding to CDB writeback on the same bank.
- Emits a one-cycle-delayed OC tag aligned with RF read data.

Parameters:
- FIFO_DEPTH, 4, request entries (power of 2, ≥2).
- ROW_W, 3, physical row index width.
- OCID_W, 3, operand-collector slot tag width ({OCID, src#}).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Valid_RAU_ReqFIFO  in  1  request valid from mapping unit
- Src1_Valid  in  1  source 1 used
- Src1_Phy_Bank_ID  in  2  source 1 bank
- Src1_Phy_Row_ID  in  ROW_W  source 1 row
- Src1_OCID_RAU_OC  in  OCID_W  source 1 destination OC slot
- Src2_Valid  in  1  source 2 used
- Src2_Phy_Bank_ID  in  2  source 2 bank
- Src2_Phy_Row_ID  in  ROW_W  source 2 row
- Src2_OCID_RAU_OC  in  OCID_W  source 2 destination OC slot
- ReqFIFO_2op_EN  in  1  both sources valid and on the same bank
- WriteValid  in  1  CDB write this cycle
- WriteBank  in  2  CDB write bank
- Full_ReqFIFO_RAU  out  1  FIFO cannot accept; mapping unit holds request
- RdEn_RF  out  4  per-bank read enable
- RdRow_RF  out  4*ROW_W  per-bank row; bank b at [b*ROW_W +: ROW_W]
- TagValid_OC  out  4  per-bank data valid to OC, registered one cycle after RdEn_RF
- TagOCID_OC  out  4*OCID_W  per-bank OC slot tag, same alignment

Behaviour:
- Reset: every output is 0, count = 0, pointers = 0, FSM = IDLE, head done bits cleared. Reset mid-operation discards all entries and any in-flight tag.
- Push:
  - A request is accepted when Valid_RAU_ReqFIFO=1, at least one SrcN_Valid=1, and count < FIFO_DEPTH.
  - A request with no valid source is dropped silently.
  - The stored entry holds both operand fields plus 2op flag.
- Full_ReqFIFO_RAU = (count == FIFO_DEPTH), combinational from registered count.
- Push and pop in the same cycle:
  - When not full: count unchanged.
  - When full: the push is refused and the pop proceeds.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: an entry pushed at cycle N is eligible for issue no earlier than N+1. There is no bypass.
- In-order issue: only the head entry is serviced. Per-operand done bits d1/d2 are set when an operand is issued; an invalid operand counts as done.
- Operand blocking: an operand is blocked in a cycle if WriteValid=1 and WriteBank equals its bank. CDB write always wins.
- FSM:
  - IDLE: count==0. No issue. Go to ISSUE when count becomes nonzero.
  - ISSUE: head serviced.
    - Different banks: every unblocked, not-done operand is issued this cycle.
    - Same bank (2op flag): only src1 is eligible until d1=1; src2 goes in a later cycle.
    - When all operands of the head are done after this cycle: pop, clear done bits, stay in ISSUE if entries remain, else go to IDLE.
    - Otherwise go to SECOND.
  - SECOND: issue the remaining operand when unblocked. Pop on issue, then go to ISSUE if entries remain, else IDLE.
- Issue encoding: RdEn_RF[bank]=1 and RdRow_RF slice = row in the same cycle; non-issued banks drive 0.
- Tag alignment: next cycle, TagValid_OC[bank]=1 and TagOCID_OC slice = that operand's OCID; otherwise 0.
- Minimum service: 1 cycle for a different-bank or single-operand entry; 2 cycles for same-bank. Each blocked cycle adds 1.

Optional Feature:
- Macro RFSCHED_CONFLICT_CNT_EN.
- When defined:
  - Extra output ConflictCnt_RF (16 bits), reset 0.
  - Increments by 1 each cycle the head has a not-done valid operand that is not issued because of a write block or same-bank serialisation.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then one request: src1 bank0 row2 OCID 3'b000, src2 bank2 row5 OCID 3'b001 → next cycle RdEn_RF=4'b0101, rows 2/5; following cycle TagValid_OC=4'b0101 with tags 000/001; FIFO empty.
- Same-bank request: both sources on bank1, rows 1/4, 2op=1 → cycle1 RdEn_RF=4'b0010 row1; cycle2 RdEn_RF=4'b0010 row4, tag 3'b011 one cycle later; pop after cycle2.
- WriteValid=1, WriteBank=2 held 2 cycles against a head operand on bank2 → no read on bank2 for 2 cycles, issued on cycle 3; ConflictCnt_RF=2 when the macro is defined.
- Push 4 single-source requests with no service progress (continuous write block) → Full_ReqFIFO_RAU=1; a 5th push with a simultaneous pop is refused; count stays 3 after the pop; pointer wrap verified over 10 pushes.
- Valid_RAU_ReqFIFO=1 with both SrcN_Valid=0 → no push, count stays 0, no RdEn.
- Assert rst while the FSM is in SECOND with 2 entries → next cycle all outputs 0, Full 0, and a subsequent request issues normally.
